// File: rtl/btn_nibble_entry.sv
// btn_nibble_entry
//   Operand entry stage for the ALU/display path. Two raw push-buttons are
//   synchronised, debounced on a slow sample tick and turned into press
//   events. A step press edits the selected hex nibble of a 16-bit word.
//   A select press moves the selection to the next nibble.
//
// Optional build macro:
//   AUTOREP_EN - when defined, holding the debounced step button generates
//                repeat step events. The first repeat comes REP_DELAY ticks
//                after the press, then one every REP_RATE ticks.
//
// Ports:
//   clk      in   1   system clock
//   rst      in   1   synchronous, active-high reset
//   tick     in   1   one-clk debounce sample enable
//   btn_raw  in   2   raw buttons, asynchronous; [0]=step, [1]=select
//   dir      in   1   0=increment, 1=decrement (used when a step applies)
//   clr      in   1   level clear of the operand word (sel is kept)
//   num      out 16   operand word, four nibbles
//   sel      out  2   index of the nibble being edited
//   step     out  1   one-clk pulse in the cycle num changes due to a step
module btn_nibble_entry #(
  parameter int unsigned DB_SAMPLES = 4,
  parameter int unsigned REP_DELAY  = 32,
  parameter int unsigned REP_RATE   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [1:0]  btn_raw,
  input  logic        dir,
  input  logic        clr,
  output logic [15:0] num,
  output logic [1:0]  sel,
  output logic        step
);

  localparam int unsigned DB_CW = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;
  localparam logic [DB_CW-1:0] DB_MAX = DB_CW'(DB_SAMPLES - 1);

  // Elaboration-time parameter sanity checks
  if (DB_SAMPLES < 1) begin : g_bad_db
    $error("btn_nibble_entry: DB_SAMPLES must be >= 1");
  end
  if (REP_DELAY < 1 || REP_RATE < 1) begin : g_bad_rep
    $error("btn_nibble_entry: REP_DELAY and REP_RATE must be >= 1");
  end

  // ---------------------------------------------------------------------
  // Two-flop synchronisers
  // ---------------------------------------------------------------------
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: the stable state flips only after DB_SAMPLES consecutive
  // tick samples that differ from it. Any agreeing sample restarts the count.
  // ---------------------------------------------------------------------
  logic [1:0]       stable_q, stable_d;
  logic [DB_CW-1:0] cnt_q [2];
  logic [DB_CW-1:0] cnt_d [2];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (sync2_q[b] == stable_q[b]) begin
          cnt_d[b] = '0;
        end else if (cnt_q[b] < DB_MAX) begin
          cnt_d[b] = cnt_q[b] + DB_CW'(1);
        end else begin
          stable_d[b] = ~stable_q[b];
          cnt_d[b]    = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Press detection: registered rising edge of the stable state, so the
  // event pulse sits in the cycle after the flip. Releases are ignored.
  // ---------------------------------------------------------------------
  logic [1:0] prev_q, press_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      press_q <= '0;
    end else begin
      prev_q  <= stable_q;
      press_q <= stable_q & ~prev_q;
    end
  end

  // ---------------------------------------------------------------------
  // Step event source
  // ---------------------------------------------------------------------
  logic step_evt;

`ifdef AUTOREP_EN
  localparam int unsigned REP_MAXV = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned HOLD_W   = (REP_MAXV > 1) ? $clog2(REP_MAXV) : 1;
  localparam logic [HOLD_W-1:0] DLY_LAST  = HOLD_W'(REP_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST = HOLD_W'(REP_RATE - 1);

  typedef enum logic {
    PH_DELAY,
    PH_RATE
  } rep_ph_e;

  rep_ph_e            ph_q, ph_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               rep_q, rep_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q   <= PH_DELAY;
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end

  // Ticks are counted while the debounced step is held. The repeat pulse is
  // registered so it lines up with press_q timing and is applied one clock later.
  always_comb begin
    ph_d   = ph_q;
    hold_d = hold_q;
    rep_d  = 1'b0;
    if (!stable_q[0] || press_q[1]) begin
      ph_d   = PH_DELAY;
      hold_d = '0;
    end else if (tick) begin
      case (ph_q)
        PH_DELAY: begin
          if (hold_q == DLY_LAST) begin
            rep_d  = 1'b1;
            hold_d = '0;
            ph_d   = PH_RATE;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        PH_RATE: begin
          if (hold_q == RATE_LAST) begin
            rep_d  = 1'b1;
            hold_d = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: begin
          ph_d   = PH_DELAY;
          hold_d = '0;
        end
      endcase
    end
  end

  assign step_evt = press_q[0] | rep_q;
`else
  assign step_evt = press_q[0];
`endif

  // ---------------------------------------------------------------------
  // Operand word and nibble select
  // ---------------------------------------------------------------------
  logic [15:0] num_q, num_d;
  logic [1:0]  sel_q, sel_d;
  logic        step_q, step_d;
  logic [3:0]  nib;

  assign nib = num_q[{sel_q, 2'b00} +: 4];

  // A step uses the current sel even if a select press advances it in the same edge.
  always_comb begin
    num_d  = num_q;
    sel_d  = sel_q;
    step_d = 1'b0;
    if (press_q[1]) begin
      sel_d = sel_q + 2'd1;
    end
    if (clr) begin
      num_d = '0;
    end else if (step_evt) begin
      num_d[{sel_q, 2'b00} +: 4] = dir ? (nib - 4'd1) : (nib + 4'd1);
      step_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q  <= '0;
      sel_q  <= '0;
      step_q <= 1'b0;
    end else begin
      num_q  <= num_d;
      sel_q  <= sel_d;
      step_q <= step_d;
    end
  end

  assign num  = num_q;
  assign sel  = sel_q;
  assign step = step_q;

endmodule

// File: tb/tb_btn_nibble_entry.sv
// Testbench for btn_nibble_entry: directed button sequences with
// hand-computed expected operand words, selections and step-pulse counts.
module tb_btn_nibble_entry;

  localparam int unsigned DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [1:0]  btn_raw;
  logic        dir;
  logic        clr;
  logic [15:0] num;
  logic [1:0]  sel;
  logic        step;

  int unsigned n_tests  = 0;
  int unsigned n_fail   = 0;
  int unsigned step_cnt = 0;
  int unsigned base;

  btn_nibble_entry #(
    .DB_SAMPLES(DB),
    .REP_DELAY (32),
    .REP_RATE  (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .btn_raw(btn_raw),
    .dir    (dir),
    .clr    (clr),
    .num    (num),
    .sel    (sel),
    .step   (step)
  );

  always #5 clk = ~clk;

  // Counts every clock cycle in which step is high.
  always @(negedge clk) begin
    if (step) step_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // n tick samples, each preceded by three idle clocks so the synchroniser
  // has settled and the event/update clocks fall between ticks.
  task automatic tk(input int unsigned n);
    repeat (n) begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic press(input logic [1:0] mask);
    btn_raw = btn_raw | mask;
    tk(DB + 2);
    btn_raw = btn_raw & ~mask;
    tk(DB + 2);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; dir = 1'b0; clr = 1'b0; btn_raw = 2'b11;

    // 1: reset with both buttons held and tick high
    repeat (2) @(posedge clk);
    #1;
    check("rst_num", 32'(num), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_step", 32'(step), 32'h0);
    rst = 1'b0; tick = 1'b0;
    base = step_cnt;
    tk(DB - 1);
    check("post_rst_nostep", step_cnt - base, 0);
    check("post_rst_num", 32'(num), 32'h0);
    tk(3);
    // both pressed together: nibble 0 increments, sel advances
    check("post_rst_num2", 32'(num), 32'h0001);
    check("post_rst_sel2", 32'(sel), 32'h1);
    check("post_rst_steps", step_cnt - base, 1);
    btn_raw = 2'b00;
    tk(DB + 2);

    // 2a: reset mid-debounce discards the count
    do_reset();
    btn_raw = 2'b01;
    tk(DB - 1);
    do_reset();
    tk(DB - 1);
    check("rst_mid_num", 32'(num), 32'h0);
    btn_raw = 2'b00;
    tk(DB + 2);

    // 2b: bounce then hold -> one step
    do_reset();
    base = step_cnt;
    btn_raw = 2'b01; tk(1);
    btn_raw = 2'b00; tk(1);
    btn_raw = 2'b01; tk(1);
    tk(6);
    check("bounce_num", 32'(num), 32'h0001);
    check("bounce_steps", step_cnt - base, 1);
    btn_raw = 2'b00;
    tk(DB + 2);
    check("release_steps", step_cnt - base, 1);

    // 3: nibble wrap without carry
    do_reset();
    dir = 1'b1; press(2'b01);
    check("dec_wrap", 32'(num), 32'h000F);
    dir = 1'b0; press(2'b01);
    check("inc_wrap", 32'(num), 32'h0000);
    dir = 1'b1; press(2'b01);
    check("dec_wrap2", 32'(num), 32'h000F);

    // 4: select cycling
    do_reset();
    dir = 1'b0;
    press(2'b10); press(2'b10);
    check("sel_two", 32'(sel), 32'h2);
    press(2'b01);
    check("step_sel2", 32'(num), 32'h0100);
    repeat (4) press(2'b10);
    check("sel_wrap", 32'(sel), 32'h2);
    check("sel_wrap_num", 32'(num), 32'h0100);

    // 5: simultaneous step and select, then with clr
    do_reset();
    press(2'b10);
    check("sim_pre_sel", 32'(sel), 32'h1);
    press(2'b11);
    check("sim_num", 32'(num), 32'h0010);
    check("sim_sel", 32'(sel), 32'h2);
    base = step_cnt;
    clr = 1'b1;
    press(2'b11);
    clr = 1'b0;
    check("clr_num", 32'(num), 32'h0000);
    check("clr_sel", 32'(sel), 32'h3);
    check("clr_nostep", step_cnt - base, 0);

    // 6: long hold. Debounced hold spans 52 ticks: press plus repeats at
    // hold ticks 32, 40, 48 when auto-repeat is built in.
    do_reset();
    base = step_cnt;
    btn_raw = 2'b01;
    tk(52);
    btn_raw = 2'b00;
    tk(DB + 2);
`ifdef AUTOREP_EN
    check("hold_num", 32'(num), 32'h0004);
    check("hold_steps", step_cnt - base, 4);
`else
    check("hold_num", 32'(num), 32'h0001);
    check("hold_steps", step_cnt - base, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
